// File: rtl/wb_regfile_hilo_pkg.sv
// wb_regfile_hilo_pkg: shared register-file defines (WB_BYPASS_EN selects same-cycle bypass in the users of this package)
package wb_regfile_hilo_pkg;
    localparam int RegAddrBus = 5;
    localparam int RegBus = 32;
    localparam int RegNum = 32;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
    localparam logic [RegBus-1:0] ZeroWord = '0;
    localparam logic WriteEnable = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable = 1'b1;
    localparam logic ReadDisable = 1'b0;
    localparam logic RstEnable = 1'b1;
endpackage

// File: rtl/wb_hilo_reg.sv
// wb_hilo_reg: HI/LO pair with paired write and optional same-cycle bypass (WB_BYPASS_EN)
module wb_hilo_reg
    import wb_regfile_hilo_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    logic [DATA_W-1:0] hi, lo;
    logic byp;
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi <= '0;
            lo <= '0;
        end else if (wb_whilo == WriteEnable) begin
            hi <= wb_hi;
            lo <= wb_lo;
        end
    end
`ifdef WB_BYPASS_EN
    assign byp = wb_whilo == WriteEnable;
`else
    assign byp = 1'b0;
`endif
    always_comb begin
        hi_o = (rst == RstEnable) ? '0 : byp ? wb_hi : hi;
        lo_o = (rst == RstEnable) ? '0 : byp ? wb_lo : lo;
    end
endmodule

// File: rtl/wb_regfile_hilo.sv
// wb_regfile_hilo: write-back GPR file with two read ports plus HI/LO pair (WB_BYPASS_EN enables same-cycle bypass)
module wb_regfile_hilo
    import wb_regfile_hilo_pkg::*;
#(
    parameter int REG_NUM = RegNum,
    parameter int ADDR_W = RegAddrBus,
    parameter int DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    if (2 ** ADDR_W != REG_NUM) begin : g_bad_cfg
        $error("wb_regfile_hilo: 2**ADDR_W must equal REG_NUM");
    end
    localparam logic [ADDR_W-1:0] NOP = ADDR_W'(NOPRegAddr);
    logic [DATA_W-1:0] regs [REG_NUM];
    logic hit1, hit2;
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wb_wreg == WriteEnable && wb_wd != NOP) begin
            regs[wb_wd] <= wb_wdata;
        end
    end
`ifdef WB_BYPASS_EN
    assign hit1 = wb_wreg == WriteEnable && wb_wd == raddr1;
    assign hit2 = wb_wreg == WriteEnable && wb_wd == raddr2;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif
    // r0 and disabled ports outrank the bypass so r0 can never read nonzero
    always_comb begin
        rdata1 = (rst == RstEnable || re1 != ReadEnable || raddr1 == NOP) ? '0 : hit1 ? wb_wdata : regs[raddr1];
        rdata2 = (rst == RstEnable || re2 != ReadEnable || raddr2 == NOP) ? '0 : hit2 ? wb_wdata : regs[raddr2];
    end
    wb_hilo_reg #(.DATA_W(DATA_W)) u_hilo (
        .clk(clk),
        .rst(rst),
        .wb_whilo(wb_whilo),
        .wb_hi(wb_hi),
        .wb_lo(wb_lo),
        .hi_o(hi_o),
        .lo_o(lo_o)
    );
endmodule
